// File: rtl/spi_slave.sv
// spi_slave
// ---------------------------------------------------------------------------
// SPI slave front end for the SPI-to-RAM path. SCLK is the system clock, so
// MOSI is sampled on every rising edge of clk while SS_n is low.
//
// A frame is ADDR_SIZE+2 bits, MSB first: {cmd[1:0], payload[ADDR_SIZE-1:0]}.
// The assembled frame goes to the RAM on rx_data with a one-cycle rx_valid
// strobe. On read-data frames the RAM's tx_data is captured on the first
// tx_valid seen after the strobe and shifted out MSB first on MISO.
//
// Ports
//   clk       system clock (also the SPI bit clock)
//   rst       synchronous active-high reset
//   MOSI      serial data from master
//   SS_n      active-low slave select; a sampled 1 aborts/ends the frame
//   MISO      serial read data to master (0 unless serialising read data)
//   rx_data   assembled frame to RAM din
//   rx_valid  one-cycle strobe, rx_data is complete
//   tx_data   RAM read data
//   tx_valid  RAM read data valid (may be held high by the RAM)
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MOSI,
  input  logic                 SS_n,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FRAME_LEN = ADDR_SIZE + 2;
  localparam int BCW       = $clog2(FRAME_LEN + 1);
  localparam int TCW       = $clog2(ADDR_SIZE + 2);

  localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_LEN - 1);
  localparam logic [BCW-1:0] FRAME_DONE = BCW'(FRAME_LEN);
  // tx_cnt counts bits already placed on MISO; TX_LAST means bit 0 is out.
  localparam logic [TCW-1:0] TX_LAST    = TCW'(ADDR_SIZE);
  localparam logic [TCW-1:0] TX_DONE    = TCW'(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [BCW-1:0]       bit_cnt;
  logic [TCW-1:0]       tx_cnt;
  // Holds the bits received so far; the last bit goes straight to rx_data.
  logic [FRAME_LEN-2:0] rx_shift;
  logic [ADDR_SIZE-1:0] tx_shift;
  logic                 rd_addr_seen;

  logic shift_en, load_rx, set_rd, tx_capture, tx_step, tx_finish;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        // First frame bit picks the path; a read is a read-data frame only
        // once a read-address frame has completed.
        CHK_CMD: begin
          if (!MOSI)             state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Datapath controls
  always_comb begin
    shift_en   = 1'b0;
    load_rx    = 1'b0;
    set_rd     = 1'b0;
    tx_capture = 1'b0;
    tx_step    = 1'b0;
    tx_finish  = 1'b0;
    if (!SS_n) begin
      case (state)
        CHK_CMD: shift_en = 1'b1;
        WRITE, READ_ADD, READ_DATA: begin
          shift_en = (bit_cnt < FRAME_DONE);
          load_rx  = (bit_cnt == LAST_BIT);
          set_rd   = (bit_cnt == LAST_BIT) && (state == READ_ADD);
          if ((state == READ_DATA) && (bit_cnt == FRAME_DONE)) begin
            // The cycle of the rx_valid strobe is skipped: a RAM that holds
            // tx_valid high would otherwise hand back stale data.
            tx_capture = (tx_cnt == '0) && tx_valid && !rx_valid;
            tx_step    = (tx_cnt != '0) && (tx_cnt < TX_LAST);
            tx_finish  = (tx_cnt == TX_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      tx_cnt       <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= load_rx;
      if (SS_n) begin
        // rd_addr_seen deliberately survives an abort.
        bit_cnt  <= '0;
        tx_cnt   <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        MISO     <= 1'b0;
      end else begin
        if (shift_en) begin
          rx_shift <= {rx_shift[FRAME_LEN-3:0], MOSI};
          bit_cnt  <= bit_cnt + 1'b1;
        end
        if (load_rx) rx_data <= {rx_shift, MOSI};
        if (set_rd)  rd_addr_seen <= 1'b1;
        if (tx_capture) begin
          MISO     <= tx_data[ADDR_SIZE-1];
          tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
          tx_cnt   <= TCW'(1);
        end else if (tx_step) begin
          MISO     <= tx_shift[ADDR_SIZE-1];
          tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
          tx_cnt   <= tx_cnt + 1'b1;
        end else if (tx_finish) begin
          MISO         <= 1'b0;
          rd_addr_seen <= 1'b0;
          tx_cnt       <= TX_DONE;
        end
      end
    end
  end

endmodule
